mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Multi-cycle sequencer for the small two-step scaling datapath used in the lesson designs. Computes b = 2·a, then c = b·a, one register stage per step, so each step's register update is observable on its own clock edge. Sits between a valid/ready producer and consumer. Owns the datapath registers and the FSM that orders their updates.

## Interface
- A_W, default 3: operand `a` width.
- B_W, default 6: intermediate `b` width; 2·a is truncated to B_W bits.
- C_W, default 6: result `c` width; product b·a is C_W-limited (wrap or saturate, see Configuration).
- CNT_W, default 8: completed-operation counter width.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort: return to IDLE, drop out_valid; counter kept.
- in_valid  in  1  producer has operand.
- in_a  in  A_W  operand a.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts.
- out_b  out  B_W  registered b.
- out_c  out  C_W  registered c.
- out_ovf  out  1  b or c lost significant bits for this operation.
- busy  out  1  state != IDLE.
- op_cnt  out  CNT_W  completed (accepted) results, wraps.

## Operation
- States: IDLE, DOUBLE, MULT, HOLD.
- IDLE: in_ready=1. On in_valid: a_q <= in_a, ovf cleared, go DOUBLE.
- DOUBLE: b_q <= {a_q,1'b0} truncated to B_W; ovf set if dropped bits nonzero; go MULT.
- MULT: full product p = b_q·a_q (B_W+A_W bits); c_q <= p mod 2^C_W (or saturated); ovf |= p ≥ 2^C_W; out_valid <= 1; go HOLD.
- HOLD: out_valid=1, out_b/out_c/out_ovf stable. On out_ready: out_valid <= 0, op_cnt <= op_cnt+1, go IDLE.
- No new operand accepted in HOLD, even with out_ready high in the same cycle; next accept is one cycle later from IDLE.
- clr has priority over every transition, including a handshake in the same cycle. It forces IDLE and out_valid=0. a_q/b_q/c_q keep their values; op_cnt does not increment.
- Operands are unsigned. All arithmetic is unsigned, at full width before truncation.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_b=0, out_c=0, out_ovf=0, busy=0, op_cnt=0.
- Reset mid-operation discards the operation, with no output pulse.
- Accept at edge E0 (in_valid & in_ready):
  - b visible after E0+1.
  - c visible and out_valid high after E0+2.
- Minimum issue interval: 4 cycles (IDLE, DOUBLE, MULT, HOLD each ≥1 cycle).
- in_ready and busy are decoded combinationally from registered state. All other outputs are registered.
- op_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Configuration
- MUL_SEQ_SAT_EN defined: on c overflow, c_q <= 2^C_W−1 (all ones); b still truncates.
- MUL_SEQ_SAT_EN undefined: c_q <= p mod 2^C_W.
- out_ovf behaviour is identical in both builds.

## Test plan
- Reset/idle: hold rst_n low 2 cycles, then release → in_ready=1, out_valid=0, out_b=0, out_c=0, op_cnt=0.
- Basic op: in_a=3 accepted at E0, out_ready=1 → out_b=6 after E0+1; out_c=18, out_ovf=0, out_valid=1 after E0+2; op_cnt=1 after E0+3.
- Overflow, defaults: in_a=7 → out_b=14, product 98:
  - without MUL_SEQ_SAT_EN → out_c=34, out_ovf=1;
  - with MUL_SEQ_SAT_EN → out_c=63, out_ovf=1.
- Backpressure: in_a=5, out_ready=0 for 5 cycles → out_valid stays 1, out_c=50 stable, in_ready=0, a second in_valid ignored; out_ready=1 → IDLE the next cycle, op_cnt +1.
- Abort: assert clr in MULT → after that edge out_valid=0, state IDLE, op_cnt unchanged. Also assert clr together with out_valid & out_ready → op_cnt unchanged.
- Async reset during HOLD: drop rst_n between edges → out_valid=0 and op_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: valid/ready bundle between the producer/consumer and mul_seq_ctrl.
//
// Signals:
//   in_valid  - producer has an operand
//   in_a      - operand a (A_W bits)
//   in_ready  - sequencer can take an operand (IDLE only)
//   out_valid - result valid, held until accepted
//   out_ready - consumer accepts the result
//   out_b     - registered intermediate b = 2*a (B_W bits)
//   out_c     - registered result c = b*a (C_W bits)
//   out_ovf   - b or c lost significant bits for this operation
//
// Modports: master = producer/consumer side, slave = sequencer side.
interface mul_seq_ctrl_if #(
    parameter int A_W = 3,
    parameter int B_W = 6,
    parameter int C_W = 6
) ();
    logic           in_valid;
    logic [A_W-1:0] in_a;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [B_W-1:0] out_b;
    logic [C_W-1:0] out_c;
    logic           out_ovf;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_b, out_c, out_ovf
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_b, out_c, out_ovf
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle sequencer for the two-step scaling datapath.
// Computes b = 2*a (DOUBLE), then c = b*a (MULT), one register update per step,
// and holds the result in HOLD until the consumer accepts it.
//
// Build option: define MUL_SEQ_SAT_EN to saturate c to all ones on overflow;
// otherwise c wraps modulo 2^C_W. out_ovf is the same in both builds.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous abort to IDLE (drops out_valid, counter kept)
//   bus    - mul_seq_ctrl_if.slave handshake/data bundle
//   busy   - state != IDLE
//   op_cnt - count of accepted results, wraps silently
module mul_seq_ctrl #(
    parameter int A_W   = 3,
    parameter int B_W   = 6,
    parameter int C_W   = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    mul_seq_ctrl_if.slave    bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DOUBLE = 2'd1;
    localparam logic [1:0] MULT   = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int P_W = B_W + A_W;

    logic [1:0]       state_q, state_d;
    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [A_W:0]     dbl_full;
    logic             dbl_ovf;
    logic [P_W-1:0]   prod;
    logic             prod_ovf;
    logic [C_W-1:0]   c_next;

    // Full-width arithmetic; truncation and overflow detection happen afterwards.
    always_comb begin
        dbl_full = {a_q, 1'b0};
        dbl_ovf  = (dbl_full >> B_W) != '0;
        prod     = P_W'(b_q) * P_W'(a_q);
        prod_ovf = (prod >> C_W) != '0;
`ifdef MUL_SEQ_SAT_EN
        c_next   = prod_ovf ? '1 : C_W'(prod);
`else
        c_next   = C_W'(prod);
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    ovf_d   = 1'b0;
                    state_d = DOUBLE;
                end
            end
            DOUBLE: begin
                b_d     = B_W'(dbl_full);
                ovf_d   = ovf_q | dbl_ovf;
                state_d = MULT;
            end
            MULT: begin
                c_d     = c_next;
                ovf_d   = ovf_q | prod_ovf;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a same-cycle handshake.
        if (clr) begin
            state_d = IDLE;
            valid_d = 1'b0;
            a_d     = a_q;
            b_d     = b_q;
            c_d     = c_q;
            ovf_d   = ovf_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_b     = b_q;
    assign bus.out_c     = c_q;
    assign bus.out_ovf   = ovf_q;
    assign op_cnt        = cnt_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed self-checking bench for mul_seq_ctrl with a result scoreboard.
module tb_mul_seq_ctrl;
    localparam int A_W   = 3;
    localparam int B_W   = 6;
    localparam int C_W   = 6;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
        logic           ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    int checks;
    int failures;
    exp_t exp_q[$];

    mul_seq_ctrl_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W)) bus ();

    mul_seq_ctrl #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .bus    (bus),
        .busy   (busy),
        .op_cnt (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: b = (2a) mod 2^B_W, p = b*a, c wraps or saturates.
    function automatic exp_t model(input int a);
        exp_t e;
        int b2;
        int p;
        b2 = 2 * a;
        p  = (b2 % (1 << B_W)) * a;
        e.b = B_W'(b2 % (1 << B_W));
`ifdef MUL_SEQ_SAT_EN
        e.c = (p >= (1 << C_W)) ? '1 : C_W'(p % (1 << C_W));
`else
        e.c = C_W'(p % (1 << C_W));
`endif
        e.ovf = (b2 >= (1 << B_W)) || (p >= (1 << C_W));
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand from IDLE; returns #1 after the accepting edge.
    task automatic send(input int a);
        bus.in_valid = 1'b1;
        bus.in_a     = A_W'(a);
        @(negedge clk);
        check("in_ready_at_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(model(a));
    endtask

    // Wait (bounded) for out_valid, then compare against the scoreboard head.
    task automatic get_result(input string tag);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_b"}, 32'(bus.out_b), 32'(e.b));
            check({tag, "_c"}, 32'(bus.out_c), 32'(e.c));
            check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e.ovf));
        end
    endtask

    initial begin
        exp_t e;
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.out_ready = 1'b0;

        // Reset / idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_b", 32'(bus.out_b), 32'd0);
        check("rst_out_c", 32'(bus.out_c), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);

        // Basic op with exact per-edge timing
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(3);
        @(negedge clk);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_in_ready", 32'(bus.in_ready), 32'd0);
        check("basic_valid_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("basic_b_e1", 32'(bus.out_b), 32'd6);
        check("basic_valid_e1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("basic_valid_e2", 32'(bus.out_valid), 32'd1);
        e = exp_q.pop_front();
        check("basic_c_e2", 32'(bus.out_c), 32'(e.c));
        check("basic_c_const", 32'(bus.out_c), 32'd18);
        check("basic_ovf_e2", 32'(bus.out_ovf), 32'd0);
        @(negedge clk);
        check("basic_op_cnt", 32'(op_cnt), 32'd1);
        check("basic_valid_done", 32'(bus.out_valid), 32'd0);
        check("basic_idle", 32'(bus.in_ready), 32'd1);

        // Overflow
        @(posedge clk);
        #1;
        send(7);
        get_result("ovf");
`ifdef MUL_SEQ_SAT_EN
        check("ovf_c_const", 32'(bus.out_c), 32'd63);
`else
        check("ovf_c_const", 32'(bus.out_c), 32'd34);
`endif
        check("ovf_flag_const", 32'(bus.out_ovf), 32'd1);
        @(negedge clk);
        check("ovf_op_cnt", 32'(op_cnt), 32'd2);

        // Backpressure: result held, extra in_valid ignored
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(5);
        get_result("bp");
        bus.in_valid = 1'b1;
        bus.in_a     = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_c", 32'(bus.out_c), 32'd50);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        // Accept while an operand is waiting: it must not be taken in HOLD
        bus.out_ready = 1'b1;
        bus.in_a      = 3'd2;
        @(negedge clk);
        check("bp_release_idle", 32'(busy), 32'd0);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_op_cnt", 32'(op_cnt), 32'd3);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        exp_q.push_back(model(2));
        get_result("next");
        @(negedge clk);
        check("next_op_cnt", 32'(op_cnt), 32'd4);

        // Abort in MULT: c keeps previous value, no completion
        @(posedge clk);
        #1;
        send(6);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_op_cnt", 32'(op_cnt), 32'd4);
        check("abort_b_kept", 32'(bus.out_b), 32'd12);
        check("abort_c_kept", 32'(bus.out_c), 32'd8);

        // clr together with a handshake
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        send(1);
        get_result("clrhs");
        clr           = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clrhs_op_cnt", 32'(op_cnt), 32'd4);
        check("clrhs_valid", 32'(bus.out_valid), 32'd0);
        check("clrhs_idle", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset during HOLD
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        send(4);
        get_result("arst");
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_op_cnt", 32'(op_cnt), 32'd0);
        check("arst_b", 32'(bus.out_b), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(3);
        get_result("post");
        @(negedge clk);
        check("post_op_cnt", 32'(op_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
